// File: rtl/snake_pkg.sv
// Shared constants, cell type and FSM states for the snake game-state engine.
// A cell packs {row, column} so it doubles as the occupancy-bitmap address.
package snake_pkg;

    localparam int GRID_W   = 64;
    localparam int GRID_H   = 48;
    localparam int MAX_LEN  = 256;
    localparam int INIT_LEN = 4;
    localparam int INIT_X   = 32;
    localparam int INIT_Y   = 24;
    localparam int PTR_W    = $clog2(MAX_LEN);
    localparam int LEN_W    = PTR_W + 1;

    localparam logic [1:0] DIR_UP    = 2'b11;
    localparam logic [1:0] DIR_DOWN  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b01;

    typedef struct packed {
        logic [5:0] y;
        logic [5:0] x;
    } cell_t;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_SEED,
        ST_IDLE,
        ST_CHECK,
        ST_DECIDE,
        ST_CLR_TAIL,
        ST_SET_HEAD,
        ST_DEAD
    } state_t;

    // Opposite directions are bitwise complements of each other in this encoding.
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return a == ~b;
    endfunction

endpackage

// File: rtl/snake_occ_ram.sv
// 4096x1 occupancy bitmap: port A is read-only (raster queries), port B is read/write (FSM).
// A read that collides with a same-cycle port-B write returns the previous contents.
module snake_occ_ram (
    input  logic        iCLK,
    input  logic [11:0] a_addr,
    output logic        a_rdata,
    input  logic [11:0] b_addr,
    input  logic        b_we,
    input  logic        b_wdata,
    output logic        b_rdata
);

    logic mem [4096];
    logic a_q;
    logic b_q;

    always_ff @(posedge iCLK) begin
        a_q <= mem[a_addr];
        b_q <= mem[b_addr];
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

    assign a_rdata = a_q;
    assign b_rdata = b_q;

endmodule

// File: rtl/snake_body_engine.sv
// Snake game-state engine: ring buffer of body cells plus occupancy bitmap, stepped one
// cell per tick with wall/self collision detection and 1-cycle pixel-query answers.
module snake_body_engine
    import snake_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iTick,
    input  logic [1:0] iDir,
    input  logic       iGrow,
    input  logic       iRestart,
    input  logic [5:0] iQ_X,
    input  logic [5:0] iQ_Y,
    output logic       oQ_Hit,
    output logic       oQ_Head,
    output logic [5:0] oHead_X,
    output logic [5:0] oHead_Y,
    output logic [8:0] oLen,
    output logic       oDead,
    output logic       oBusy
);

    state_t            state_q, state_d;
    logic [1:0]        dir_q, dir_d;
    logic              grow_q, grow_d;
    cell_t             next_q, next_d;
    cell_t             head_q, head_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [11:0]       cnt_q, cnt_d;
    logic              q_en_q, q_en_d;
    logic              q_head_q, q_head_d;

    cell_t             ring_mem [MAX_LEN];
    logic              ring_we;
    cell_t             ring_wdata;

    logic [11:0]       b_addr;
    logic              b_we;
    logic              b_wdata;
    logic              b_rdata;
    logic              a_rdata;

    cell_t             init_cell;
    cell_t             tail_cell;
    cell_t             seed_cell;
    cell_t             step_cell;
    logic              step_wall;
    logic [1:0]        tick_dir;

    snake_occ_ram u_occ (
        .iCLK    (iCLK),
        .a_addr  ({iQ_Y, iQ_X}),
        .a_rdata (a_rdata),
        .b_addr  (b_addr),
        .b_we    (b_we),
        .b_wdata (b_wdata),
        .b_rdata (b_rdata)
    );

    assign init_cell   = '{y: 6'(INIT_Y), x: 6'(INIT_X)};
    assign tail_cell   = ring_mem[rd_ptr_q];
    assign seed_cell.y = 6'(INIT_Y);
    assign seed_cell.x = 6'(INIT_X - INIT_LEN + 1) + cnt_q[5:0];

    // Candidate head for a tick arriving now; wrap of the 6-bit coordinate counts as a wall.
    always_comb begin
        tick_dir  = is_reverse(iDir, dir_q) ? dir_q : iDir;
        step_cell = head_q;
        step_wall = 1'b0;
        case (tick_dir)
            DIR_UP: begin
                step_wall   = (head_q.y == 6'd0);
                step_cell.y = head_q.y - 6'd1;
            end
            DIR_DOWN: begin
                step_wall   = (head_q.y >= 6'(GRID_H - 1));
                step_cell.y = head_q.y + 6'd1;
            end
            DIR_LEFT: begin
                step_wall   = (head_q.x == 6'd0);
                step_cell.x = head_q.x - 6'd1;
            end
            default: begin
                step_wall   = (head_q.x >= 6'(GRID_W - 1));
                step_cell.x = head_q.x + 6'd1;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        grow_d     = grow_q;
        next_d     = next_q;
        head_d     = head_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        b_addr     = next_q;
        b_we       = 1'b0;
        b_wdata    = 1'b0;
        ring_we    = 1'b0;
        ring_wdata = next_q;

        case (state_q)
            ST_CLEAR: begin
                b_addr = cnt_q;
                b_we   = 1'b1;
                cnt_d  = cnt_q + 12'd1;
                if (cnt_q == 12'hFFF) begin
                    cnt_d   = '0;
                    state_d = ST_SEED;
                end
            end
            ST_SEED: begin
                b_addr     = seed_cell;
                b_we       = 1'b1;
                b_wdata    = 1'b1;
                ring_we    = 1'b1;
                ring_wdata = seed_cell;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                len_d      = len_q + 1'b1;
                cnt_d      = cnt_q + 12'd1;
                if (cnt_q == 12'(INIT_LEN - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (iTick) begin
                    if (step_wall) begin
                        state_d = ST_DEAD;
                    end else begin
                        dir_d   = tick_dir;
                        grow_d  = iGrow && (len_q != LEN_W'(MAX_LEN));
                        next_d  = step_cell;
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                state_d = ST_DECIDE;
            end
            // Moving into the cell the tail is vacating is legal unless the tail is being kept.
            ST_DECIDE: begin
                if (b_rdata && (grow_q || next_q != tail_cell)) begin
                    state_d = ST_DEAD;
                end else if (!grow_q) begin
                    state_d = ST_CLR_TAIL;
                end else begin
                    state_d = ST_SET_HEAD;
                end
            end
            ST_CLR_TAIL: begin
                b_addr   = tail_cell;
                b_we     = 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
                len_d    = len_q - 1'b1;
                state_d  = ST_SET_HEAD;
            end
            ST_SET_HEAD: begin
                b_we     = 1'b1;
                b_wdata  = 1'b1;
                ring_we  = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                len_d    = len_q + 1'b1;
                head_d   = next_q;
                state_d  = ST_IDLE;
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
        endcase

        if (iRestart) begin
            state_d  = ST_CLEAR;
            dir_d    = DIR_RIGHT;
            grow_d   = 1'b0;
            head_d   = init_cell;
            len_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end

        q_en_d   = (state_q != ST_CLEAR) && (state_q != ST_SEED);
        q_head_d = q_en_d && ({iQ_Y, iQ_X} == head_q);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= ST_CLEAR;
            dir_q    <= DIR_RIGHT;
            grow_q   <= 1'b0;
            next_q   <= init_cell;
            head_q   <= init_cell;
            len_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            q_en_q   <= 1'b0;
            q_head_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            grow_q   <= grow_d;
            next_q   <= next_d;
            head_q   <= head_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            q_en_q   <= q_en_d;
            q_head_q <= q_head_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (ring_we) begin
            ring_mem[wr_ptr_q] <= ring_wdata;
        end
    end

    assign oQ_Hit  = q_en_q & a_rdata;
    assign oQ_Head = q_head_q;
    assign oHead_X = head_q.x;
    assign oHead_Y = head_q.y;
    assign oLen    = len_q;
    assign oDead   = (state_q == ST_DEAD);
    assign oBusy   = (state_q != ST_IDLE) && (state_q != ST_DEAD);

endmodule

// File: tb/tb_snake_body_engine.sv
// Scoreboard bench for snake_body_engine: a queue-of-cells game model predicts every
// query answer and step outcome; a negedge monitor pops and compares DUT responses.
module tb_snake_body_engine;

    logic       iCLK     = 1'b0;
    logic       iRST_N   = 1'b0;
    logic       iTick    = 1'b0;
    logic [1:0] iDir     = 2'b01;
    logic       iGrow    = 1'b0;
    logic       iRestart = 1'b0;
    logic [5:0] iQ_X     = '0;
    logic [5:0] iQ_Y     = '0;
    logic       oQ_Hit;
    logic       oQ_Head;
    logic [5:0] oHead_X;
    logic [5:0] oHead_Y;
    logic [8:0] oLen;
    logic       oDead;
    logic       oBusy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    snake_body_engine dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iTick    (iTick),
        .iDir     (iDir),
        .iGrow    (iGrow),
        .iRestart (iRestart),
        .iQ_X     (iQ_X),
        .iQ_Y     (iQ_Y),
        .oQ_Hit   (oQ_Hit),
        .oQ_Head  (oQ_Head),
        .oHead_X  (oHead_X),
        .oHead_Y  (oHead_Y),
        .oLen     (oLen),
        .oDead    (oDead),
        .oBusy    (oBusy)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc++;

    // kind 0: query (x, y, e0=hit, e1=head); kind 1: state (e0..e4 = hx, hy, len, dead, busy)
    typedef struct {
        int kind;
        int issue;
        int x;
        int y;
        int e0;
        int e1;
        int e2;
        int e3;
        int e4;
    } sb_t;
    sb_t sb_q[$];

    // Game model: body cells coded y*64+x, tail at the front, head at the back.
    int body[$];
    int m_dir;
    bit m_dead;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic bit model_has(input int c);
        foreach (body[i]) if (body[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_head();
        return body[body.size() - 1];
    endfunction

    function automatic void model_seed();
        body.delete();
        for (int i = 0; i < 4; i++) body.push_back(24 * 64 + 29 + i);
        m_dir  = 1;
        m_dead = 1'b0;
    endfunction

    // Returns 0 moved, 1 moved+grew, 2 self hit, 3 wall hit, 4 ignored (already dead).
    function automatic int model_step(input int d, input bit g);
        int hx, hy, n;
        bit grow;
        int nb[$];
        if (m_dead) return 4;
        if ((d ^ m_dir) == 3) d = m_dir;
        hx = model_head() % 64;
        hy = model_head() / 64;
        case (d)
            3: hy = hy - 1;
            0: hy = hy + 1;
            2: hx = hx - 1;
            default: hx = hx + 1;
        endcase
        if (hx < 0 || hx >= 64 || hy < 0 || hy >= 48) begin
            m_dead = 1'b1;
            return 3;
        end
        m_dir = d;
        n     = hy * 64 + hx;
        grow  = g && (body.size() < 256);
        nb    = body;
        if (!grow) void'(nb.pop_front());
        foreach (nb[i]) begin
            if (nb[i] == n) begin
                m_dead = 1'b1;
                return 2;
            end
        end
        nb.push_back(n);
        body = nb;
        return grow ? 1 : 0;
    endfunction

    task automatic push_state_exp(input int hx, input int hy, input int len, input int dead, input int busy);
        sb_t e;
        e.kind = 1; e.issue = cyc; e.x = 0; e.y = 0;
        e.e0 = hx; e.e1 = hy; e.e2 = len; e.e3 = dead; e.e4 = busy;
        sb_q.push_back(e);
    endtask

    task automatic push_state();
        push_state_exp(model_head() % 64, model_head() / 64, body.size(), m_dead, 0);
    endtask

    // Drive one query this cycle and advance; en=0 when query outputs must be forced low.
    task automatic query_cell(input int x, input int y, input bit en);
        sb_t e;
        iQ_X = x[5:0];
        iQ_Y = y[5:0];
        e.kind = 0; e.issue = cyc; e.x = x; e.y = y;
        e.e0 = en && model_has(y * 64 + x);
        e.e1 = en && (y * 64 + x == model_head());
        e.e2 = 0; e.e3 = 0; e.e4 = 0;
        sb_q.push_back(e);
        @(negedge iCLK);
    endtask

    task automatic query_sweep(input int extra);
        int hc;
        int tc;
        hc = model_head();
        tc = body[0];
        query_cell(hc % 64, hc / 64, 1'b1);
        query_cell(tc % 64, tc / 64, 1'b1);
        query_cell(extra % 64, extra / 64, 1'b1);
        query_cell((hc % 64 + 1) % 64, hc / 64, 1'b1);
        for (int i = 0; i < 3; i++) query_cell($urandom_range(63), $urandom_range(63), 1'b1);
        @(negedge iCLK);
    endtask

    task automatic wait_seed();
        int k;
        k = 0;
        while (oBusy && k < 5000) begin
            @(negedge iCLK);
            k++;
        end
        if (oBusy) checkOutput("seed_timeout", 1, 0);
        push_state();
        for (int x = 28; x <= 33; x++) query_cell(x, 24, 1'b1);
        query_cell(32, 23, 1'b1);
        @(negedge iCLK);
    endtask

    task automatic do_restart();
        @(negedge iCLK);
        iRestart = 1'b1;
        @(negedge iCLK);
        iRestart = 1'b0;
        model_seed();
        push_state_exp(32, 24, 0, 0, 1);
        query_cell(32, 24, 1'b0);
        query_cell(30, 24, 1'b0);
        wait_seed();
    endtask

    // One step request: drive the tick, measure the busy window, then scoreboard the result.
    task automatic applyStimulus(input int d, input bit g, input bit double_tick);
        int outcome;
        int k;
        int old_tail;
        int exp_lat;
        iDir     = d[1:0];
        iGrow    = g;
        iTick    = 1'b1;
        old_tail = body[0];
        outcome  = model_step(d, g);
        @(negedge iCLK);
        iTick = double_tick;
        k = 1;
        while (oBusy && k < 12) begin
            @(negedge iCLK);
            iTick = 1'b0;
            k++;
        end
        iTick = 1'b0;
        case (outcome)
            0:       exp_lat = 5;
            1:       exp_lat = 4;
            2:       exp_lat = 3;
            default: exp_lat = 1;
        endcase
        checkOutput($sformatf("step_busy_cycles(outcome %0d)", outcome), k, exp_lat);
        push_state();
        query_sweep(old_tail);
    endtask

    // Monitor: compares every scoreboard entry one clock after it was issued.
    always @(negedge iCLK) begin : monitor
        sb_t e;
        while (sb_q.size() > 0 && sb_q[0].issue < cyc) begin
            e = sb_q.pop_front();
            if (e.kind == 0) begin
                checkOutput($sformatf("q_hit(%0d,%0d)", e.x, e.y), int'(oQ_Hit), e.e0);
                checkOutput($sformatf("q_head(%0d,%0d)", e.x, e.y), int'(oQ_Head), e.e1);
            end else begin
                checkOutput("head_x", int'(oHead_X), e.e0);
                checkOutput("head_y", int'(oHead_Y), e.e1);
                checkOutput("len", int'(oLen), e.e2);
                checkOutput("dead", int'(oDead), e.e3);
                checkOutput("busy", int'(oBusy), e.e4);
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int restarts;
        int d;
        model_seed();
        repeat (3) @(negedge iCLK);
        push_state_exp(32, 24, 0, 0, 1);
        query_cell(32, 24, 1'b0);
        iRST_N = 1'b1;
        wait_seed();

        $display("[TB] basic steps");
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 1'b1);
        applyStimulus(3, 1'b1, 1'b0);

        $display("[TB] wall run");
        while (!m_dead && model_head() % 64 < 63) applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(3, 1'b1, 1'b0);
        do_restart();

        $display("[TB] self collision");
        applyStimulus(1, 1'b1, 1'b0);
        applyStimulus(3, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        do_restart();

        $display("[TB] tail chase loop");
        applyStimulus(3, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);

        $display("[TB] random walk");
        restarts = 0;
        for (int i = 0; i < 250; i++) begin
            if (m_dead) begin
                if (restarts >= 5) break;
                restarts++;
                do_restart();
            end
            d = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : m_dir;
            applyStimulus(d, $urandom_range(2) == 0, $urandom_range(7) == 0);
        end

        repeat (3) @(negedge iCLK);
        checkOutput("scoreboard_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
